// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU: sequencer state encoding and the
// opcode/function values the sequencer and instruction decoder both look at.
package cpu_pkg;

  // Encodings are visible to the instruction decoder; do not reorder.
  typedef enum logic [2:0] {
    StFetch   = 3'd0,
    StLoad    = 3'd1,
    StMem     = 3'd2,
    StExec    = 3'd3,
    StMultDiv = 3'd4,
    StHalt    = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LB    = 6'd32;
  localparam logic [5:0] OP_LH    = 6'd33;
  localparam logic [5:0] OP_LWL   = 6'd34;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_LBU   = 6'd36;
  localparam logic [5:0] OP_LHU   = 6'd37;
  localparam logic [5:0] OP_LWR   = 6'd38;
  localparam logic [5:0] OP_SB    = 6'd40;
  localparam logic [5:0] OP_SH    = 6'd41;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_DIV   = 6'd26;
  localparam logic [5:0] FN_DIVU  = 6'd27;

  // Loads occupy the contiguous opcode range LB..LWR.
  function automatic logic is_load(input logic [5:0] op);
    return (op >= OP_LB) && (op <= OP_LWR);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Only the dividers need the MULTDIV wait; MULT/MULTU finish in EXEC.
  function automatic logic is_div(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE) && ((fn == FN_DIV) || (fn == FN_DIVU));
  endfunction

endpackage

// File: rtl/cpu_state_sequencer_if.sv
// Control bundle between the state sequencer (slave) and the rest of the CPU
// (master): bus stall and instruction fields in, state and strobes out.
interface cpu_state_sequencer_if;
  import cpu_pkg::*;

  logic        waitrequest;
  logic [5:0]  opcode;
  logic [5:0]  function_code;
  logic [31:0] pc_value;

  state_t      state;
  logic        active;
  logic        ir_write_enable;
  logic        data_write_enable;
  logic        pc_write_enable;
  logic        div_start;
  logic        div_busy;

  modport master (
    output waitrequest, opcode, function_code, pc_value,
    input  state, active, ir_write_enable, data_write_enable, pc_write_enable,
           div_start, div_busy
  );

  modport slave (
    input  waitrequest, opcode, function_code, pc_value,
    output state, active, ir_write_enable, data_write_enable, pc_write_enable,
           div_start, div_busy
  );

endinterface

// File: rtl/multdiv_counter.sv
// Loadable down-counter timing the iterative divider. Loads DIV_CYCLES-1 and
// counts down to zero, where it sticks until the next load.
module multdiv_counter #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int unsigned CntW = $clog2(DIV_CYCLES);
  localparam logic [CntW-1:0] LoadVal = CntW'(DIV_CYCLES - 1);

  logic [CntW-1:0] count_q, count_d;

  // Load has priority; decrement saturates at zero so the count never wraps.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LoadVal;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Count register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/cpu_state_sequencer.sv
// Multicycle CPU state sequencer: FETCH -> LOAD -> MEM -> [MULTDIV] -> EXEC,
// stalling on waitrequest for memory transfers and halting when PC reaches 0.
module cpu_state_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  cpu_state_sequencer_if.slave  bus
);

  state_t state_q, state_d;
  logic   run_q;
  logic   div_start_q;
  logic   div_enter;
  logic   cnt_zero;
  logic   ir_we, data_we, pc_we;
  logic   mem_xfer;
  logic   pc_zero;
  state_t mem_exit;

  assign mem_xfer = is_load(bus.opcode) || is_store(bus.opcode);
  assign mem_exit = is_div(bus.opcode, bus.function_code) ? StMultDiv : StExec;
  assign pc_zero  = (bus.pc_value == 32'd0);

  // Next-state and strobe decode. Nothing advances until the first cycle out
  // of reset, so no strobe can fire while active is still low.
  always_comb begin
    state_d   = state_q;
    ir_we     = 1'b0;
    data_we   = 1'b0;
    pc_we     = 1'b0;
    div_enter = 1'b0;
    if (run_q) begin
      case (state_q)
        StFetch: begin
          if (pc_zero) begin
            state_d = StHalt;
          end else if (!bus.waitrequest) begin
            ir_we   = 1'b1;
            state_d = StLoad;
          end
        end
        StLoad: begin
          state_d = StMem;
        end
        StMem: begin
          if (mem_xfer) begin
            if (!bus.waitrequest) begin
              data_we = is_load(bus.opcode);
              state_d = mem_exit;
            end
          end else begin
            state_d = mem_exit;
          end
          div_enter = (state_d == StMultDiv);
        end
        StMultDiv: begin
          if (cnt_zero) begin
            state_d = StExec;
          end
        end
        StExec: begin
          pc_we   = 1'b1;
          state_d = StFetch;
        end
        StHalt: begin
          state_d = StHalt;
        end
        default: begin
          state_d = StHalt;
        end
      endcase
    end
  end

  // State, run flag and registered divider start pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StFetch;
      run_q       <= 1'b0;
      div_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      div_start_q <= div_enter;
    end
  end

  multdiv_counter #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_multdiv_counter (
    .clk   (clk),
    .reset (reset),
    .load  (div_enter),
    .dec   (state_q == StMultDiv),
    .zero  (cnt_zero)
  );

  // active drops combinationally in a FETCH at PC 0 so the decoder never
  // issues that read.
  assign bus.active            = run_q && (state_q != StHalt) &&
                                 (state_q inside {StFetch, StLoad, StMem, StExec, StMultDiv}) &&
                                 !((state_q == StFetch) && pc_zero);
  assign bus.state             = state_q;
  assign bus.ir_write_enable   = ir_we;
  assign bus.data_write_enable = data_we;
  assign bus.pc_write_enable   = pc_we;
  assign bus.div_start         = div_start_q;
  assign bus.div_busy          = (state_q == StMultDiv);

endmodule

// File: tb/tb_cpu_state_sequencer.sv
// Directed bench for cpu_state_sequencer: two instances (DIV_CYCLES 32 and 4)
// share clock, reset and inputs; expected values are hand-computed per cycle.
module tb_cpu_state_sequencer;

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_MEM     = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_MULTDIV = 3'd4;
  localparam logic [2:0] S_HALT    = 3'd5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  cpu_state_sequencer_if bus ();
  cpu_state_sequencer_if bus4 ();

  assign bus4.waitrequest   = bus.waitrequest;
  assign bus4.opcode        = bus.opcode;
  assign bus4.function_code = bus.function_code;
  assign bus4.pc_value      = bus.pc_value;

  cpu_state_sequencer #(
    .DIV_CYCLES (32)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  cpu_state_sequencer #(
    .DIV_CYCLES (4)
  ) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_ctl(input string tag, input logic [2:0] st, input logic ir,
                            input logic dw, input logic pc);
    chk({tag, ".state"}, 32'(bus.state), 32'(st));
    chk({tag, ".ir_we"}, 32'(bus.ir_write_enable), 32'(ir));
    chk({tag, ".data_we"}, 32'(bus.data_write_enable), 32'(dw));
    chk({tag, ".pc_we"}, 32'(bus.pc_write_enable), 32'(pc));
  endtask

  // Advance to the next low phase, apply waitrequest, let outputs settle.
  task automatic tick(input logic wr);
    @(negedge clk);
    bus.waitrequest = wr;
    #1;
  endtask

  initial begin
    bus.waitrequest   = 1'b0;
    bus.opcode        = 6'd0;
    bus.function_code = 6'd33;  // ADDU
    bus.pc_value      = 32'h0040_0000;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    expect_ctl("reset", S_FETCH, 1'b0, 1'b0, 1'b0);
    chk("reset.active", 32'(bus.active), 32'd0);
    chk("reset.div_busy", 32'(bus.div_busy), 32'd0);
    chk("reset.div_start", 32'(bus.div_start), 32'd0);
    reset = 1'b0;

    // ADDU, no wait states
    tick(1'b0);
    expect_ctl("addu.fetch", S_FETCH, 1'b1, 1'b0, 1'b0);
    chk("addu.active", 32'(bus.active), 32'd1);
    tick(1'b0); expect_ctl("addu.load", S_LOAD, 1'b0, 1'b0, 1'b0);
    tick(1'b0); expect_ctl("addu.mem", S_MEM, 1'b0, 1'b0, 1'b0);
    tick(1'b0); expect_ctl("addu.exec", S_EXEC, 1'b0, 1'b0, 1'b1);

    // LW: 3 fetch waits, 2 mem waits
    bus.opcode = 6'd35;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1); expect_ctl("lw.fetch_wait", S_FETCH, 1'b0, 1'b0, 1'b0);
    end
    tick(1'b0); expect_ctl("lw.fetch", S_FETCH, 1'b1, 1'b0, 1'b0);
    tick(1'b1); expect_ctl("lw.load", S_LOAD, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick(1'b1); expect_ctl("lw.mem_wait", S_MEM, 1'b0, 1'b0, 1'b0);
    end
    tick(1'b0); expect_ctl("lw.mem", S_MEM, 1'b0, 1'b1, 1'b0);
    tick(1'b0); expect_ctl("lw.exec", S_EXEC, 1'b0, 1'b0, 1'b1);

    // SW: 5 mem waits, no load-data strobe
    bus.opcode = 6'd43;
    tick(1'b0); expect_ctl("sw.fetch", S_FETCH, 1'b1, 1'b0, 1'b0);
    tick(1'b0); expect_ctl("sw.load", S_LOAD, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1); expect_ctl("sw.mem_wait", S_MEM, 1'b0, 1'b0, 1'b0);
    end
    tick(1'b0); expect_ctl("sw.mem", S_MEM, 1'b0, 1'b0, 1'b0);
    tick(1'b0); expect_ctl("sw.exec", S_EXEC, 1'b0, 1'b0, 1'b1);

    // DIVU: 32-cycle and 4-cycle instances side by side
    bus.opcode        = 6'd0;
    bus.function_code = 6'd27;
    tick(1'b0); expect_ctl("divu.fetch", S_FETCH, 1'b1, 1'b0, 1'b0);
    tick(1'b0); expect_ctl("divu.load", S_LOAD, 1'b0, 1'b0, 1'b0);
    tick(1'b0); expect_ctl("divu.mem", S_MEM, 1'b0, 1'b0, 1'b0);
    chk("divu.mem.div_start", 32'(bus.div_start), 32'd0);
    for (int i = 0; i < 32; i++) begin
      tick(1'b1);
      chk("divu32.state", 32'(bus.state), 32'(S_MULTDIV));
      chk("divu32.busy", 32'(bus.div_busy), 32'd1);
      chk("divu32.start", 32'(bus.div_start), (i == 0) ? 32'd1 : 32'd0);
      if (i < 4) begin
        chk("divu4.state", 32'(bus4.state), 32'(S_MULTDIV));
        chk("divu4.busy", 32'(bus4.div_busy), 32'd1);
        chk("divu4.start", 32'(bus4.div_start), (i == 0) ? 32'd1 : 32'd0);
      end else if (i == 4) begin
        chk("divu4.exec", 32'(bus4.state), 32'(S_EXEC));
        chk("divu4.exec_pc_we", 32'(bus4.pc_write_enable), 32'd1);
        chk("divu4.exec_busy", 32'(bus4.div_busy), 32'd0);
      end else begin
        chk("divu4.fetch_stall", 32'(bus4.state), 32'(S_FETCH));
      end
    end
    tick(1'b0); expect_ctl("divu32.exec", S_EXEC, 1'b0, 1'b0, 1'b1);
    chk("divu32.exec_busy", 32'(bus.div_busy), 32'd0);

    // Bring both instances back into lockstep
    reset = 1'b1;
    tick(1'b0);
    chk("resync.active", 32'(bus.active), 32'd0);
    reset = 1'b0;
    tick(1'b0); expect_ctl("resync.fetch", S_FETCH, 1'b1, 1'b0, 1'b0);

    // Reset during MULTDIV cycle 10
    tick(1'b0); expect_ctl("rstdiv.load", S_LOAD, 1'b0, 1'b0, 1'b0);
    tick(1'b0); expect_ctl("rstdiv.mem", S_MEM, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'(i % 2));
      chk("rstdiv.multdiv", 32'(bus.state), 32'(S_MULTDIV));
    end
    reset = 1'b1;
    tick(1'b0);
    expect_ctl("rstdiv.after", S_FETCH, 1'b0, 1'b0, 1'b0);
    chk("rstdiv.busy", 32'(bus.div_busy), 32'd0);
    chk("rstdiv.active", 32'(bus.active), 32'd0);
    chk("rstdiv.div_start", 32'(bus.div_start), 32'd0);
    chk("rstdiv.dut4_state", 32'(bus4.state), 32'(S_FETCH));
    reset = 1'b0;
    bus.function_code = 6'd33;
    tick(1'b0);
    expect_ctl("rstdiv.refetch", S_FETCH, 1'b1, 1'b0, 1'b0);
    chk("rstdiv.reactive", 32'(bus.active), 32'd1);
    tick(1'b0); expect_ctl("rstdiv.reload", S_LOAD, 1'b0, 1'b0, 1'b0);
    tick(1'b0); expect_ctl("rstdiv.remem", S_MEM, 1'b0, 1'b0, 1'b0);
    tick(1'b0); expect_ctl("rstdiv.reexec", S_EXEC, 1'b0, 1'b0, 1'b1);

    // PC reaches 0: suppressed fetch, then absorbing HALT
    bus.pc_value = 32'd0;
    tick(1'b0);
    expect_ctl("halt.fetch", S_FETCH, 1'b0, 1'b0, 1'b0);
    chk("halt.fetch_active", 32'(bus.active), 32'd0);
    for (int i = 0; i < 100; i++) begin
      tick(1'(i % 2));
      expect_ctl("halt.hold", S_HALT, 1'b0, 1'b0, 1'b0);
      chk("halt.active", 32'(bus.active), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
